// File: rtl/digit_serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// digit_serial_add_ctrl_if
//   Request/result bundle for the digit-serial adder/subtractor.
//   Request side : start / in_ready handshake with operands a, b, ci, sub.
//   Result side  : out_valid / out_ready handshake with result s, co, ovf.
//   master : requester/consumer view (drives operands and out_ready).
//   slave  : the arithmetic block's view.
// ---------------------------------------------------------------------------
interface digit_serial_add_ctrl_if #(
  parameter int W = 16
);
  logic         start;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         sub;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output start, a, b, ci, sub, out_ready,
    input  in_ready, s, co, ovf, out_valid
  );

  modport slave (
    input  start, a, b, ci, sub, out_ready,
    output in_ready, s, co, ovf, out_valid
  );
endinterface

// File: rtl/digit_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// digit_serial_add_ctrl
//   Adds (A + B + ci) or subtracts (A - B) two W-bit operands using a single
//   4-bit ripple-carry slice, one digit per clock, least-significant digit
//   first. The inter-digit carry is kept in a register.
//
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - slave modport of digit_serial_add_ctrl_if
//              (start/in_ready request, a/b/ci/sub operands,
//               s/co/ovf result, out_valid/out_ready result handshake)
//
//   Timing: request accepted at edge 0, digits processed at edges 1..W/4,
//   out_valid high from edge W/4 until the result is taken.
// ---------------------------------------------------------------------------
module digit_serial_add_ctrl #(
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  digit_serial_add_ctrl_if.slave bus
);

  localparam int NDIG = W / 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((W % 4) != 0 || W < 4) begin : g_bad_width
      $error("digit_serial_add_ctrl: W must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [W-1:0]    r_opa;
  logic [W-1:0]    r_opb;
  logic [W-1:0]    r_res;
  logic            r_carry;
  logic            r_co;
  logic            r_ovf;
  logic [CW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_step;
  logic            w_last;
  logic [3:0]      w_sum;
  logic [4:0]      w_carry;
  logic            w_ovf;
  logic [W-1:0]    w_res_nxt;

  assign w_last = (r_cnt == CW'(NDIG - 1));

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // -------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    w_accept      = 1'b0;
    w_step        = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // 4-bit ripple-carry slice on the low digit of the operand shift registers.
  // The carry into bit 3 is kept so overflow can be taken from the last digit.
  // -------------------------------------------------------------------------
  always_comb begin
    w_carry    = '0;
    w_sum      = '0;
    w_carry[0] = r_carry;
    for (int i = 0; i < 4; i++) begin
      w_sum[i]     = r_opa[i] ^ r_opb[i] ^ w_carry[i];
      w_carry[i+1] = (r_opa[i] & r_opb[i]) | (w_carry[i] & (r_opa[i] ^ r_opb[i]));
    end
  end

  assign w_ovf = w_carry[4] ^ w_carry[3];

  // New digit enters at the MSB end; after NDIG shifts the first digit
  // computed sits at bits [3:0].
  generate
    if (W == 4) begin : g_res_single
      assign w_res_nxt = w_sum;
    end else begin : g_res_shift
      assign w_res_nxt = {w_sum, r_res[W-1:4]};
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: all datapath registers are plain flops (no RAM), so they are all
  // cleared by reset; an abort mid-operation leaves no stale result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
      r_opa   <= bus.a;
      r_opb   <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub ? 1'b1 : bus.ci;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_opa   <= r_opa >> 4;
      r_opb   <= r_opb >> 4;
      r_res   <= w_res_nxt;
      r_carry <= w_carry[4];
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_co  <= w_carry[4];
        r_ovf <= w_ovf;
      end
    end
  end

  assign bus.s   = r_res;
  assign bus.co  = r_co;
  assign bus.ovf = r_ovf;

endmodule

// File: doc/digit_serial_add_ctrl.md
Name: digit_serial_add_ctrl

Overview:
- Sequencer that adds or subtracts two W-bit operands by driving one internal 4-bit ripple-carry adder slice once per clock.
- Processes the operands least-significant digit first and registers the carry between digits.
- Trades W/4 cycles of latency for the area of a single 4-bit slice.
- Sits between a requester (valid/ready style start) and a consumer (valid/ready result).

Parameters:
W  16  operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)

Ports:
clk        input   1  clock, rising edge
rst_n      input   1  asynchronous active-low reset
start      input   1  request valid; accepted when start && in_ready
in_ready   output  1  block idle, can accept a request
a          input   W  operand A, sampled on acceptance
b          input   W  operand B, sampled on acceptance
ci         input   1  carry-in for add (chaining), sampled on acceptance; ignored for sub
sub        input   1  1 = A - B, 0 = A + B + ci; sampled on acceptance
s          output  W  result
co         output  1  carry-out of MSB digit (sub: 1 = no borrow)
ovf        output  1  two's-complement overflow
out_valid  output  1  result valid
out_ready  input   1  consumer accepts result when out_valid && out_ready

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; all internal registers clear.
  - Outputs: in_ready=1 after release; s=0, co=0, ovf=0, out_valid=0.
  - Reset mid-operation aborts the operation; no result is produced.
- Constants:
  - NDIG = W/4.
  - Digit counter is ceil(log2(NDIG)) bits wide, minimum 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On start, at edge 0: latch a into opa and (sub ? ~b : b) into opb; carry register = (sub ? 1 : ci); digit counter = 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the slice adds opa[3:0] + opb[3:0] + carry.
  - The 4-bit sum shifts into the MSB end of the result shift register; opa and opb shift right by 4; the carry register takes the slice carry-out; the counter increments.
  - On the cycle with counter == NDIG-1:
    - Final carry goes to co.
    - ovf = carry into MSB XOR carry out of MSB, computed inside the last slice.
    - Go to DONE.
- Latency: acceptance at edge 0; digits are processed at edges 1..NDIG; out_valid is high from edge NDIG onward. For W=16 that is 4 cycles.
- DONE:
  - out_valid=1; s, co and ovf are stable.
  - Hold indefinitely while out_ready=0 (back-pressure).
  - When out_ready=1, go to IDLE at the next edge; out_valid drops. s, co and ovf keep their last values until the next acceptance.
- start while in_ready=0 is ignored and never queued. The requester must hold start until it is accepted.
- start in the same cycle as DONE handshake: not accepted (in_ready=0 in DONE). It is accepted in the following IDLE cycle if still asserted.
- Operands are sampled only at acceptance. Changes to a, b, ci and sub during RUN/DONE have no effect.
- Arithmetic is modulo 2^W. Subtraction is A + ~B + 1, so co=1 means A >= B unsigned.
- W=4: exactly one RUN cycle.

Test Plan:
- W=16, add 0x1234 + 0x4321, ci=0 -> out_valid at edge 4 after acceptance; s=0x5555, co=0, ovf=0; in_ready=0 during edges 1-4.
- Add 0xFFFF + 0x0001, ci=0 -> s=0x0000, co=1, ovf=0 (carry ripples through every digit). Add 0x0000 + 0x0000, ci=1 -> s=0x0001, co=0.
- Sub 0x0005 - 0x0007 -> s=0xFFFE, co=0, ovf=0. Sub 0x8000 - 0x0001 -> s=0x7FFF, co=1, ovf=1.
- Add 0x7FFF + 0x0001 -> s=0x8000, ovf=1, co=0. Hold out_ready=0 for 5 cycles -> out_valid, s and ovf stay stable. Then out_ready=1 -> IDLE next edge and in_ready=1. start asserted during RUN is not accepted.
- Back-to-back: start held continuously with two requests -> second accepted in the IDLE cycle after the first DONE handshake, and its result is correct.
- Assert rst_n=0 asynchronously mid-RUN (after digit 2) -> out_valid=0, s=0, co=0, ovf=0 immediately. After release, in_ready=1 and a new add 0x00FF + 0x0001 gives s=0x0100.
